// File: rtl/fp_round_if.sv
// Valid/ready bundle between the mantissa normalizer, the round-and-pack stage and its consumer.
interface fp_round_if #(
    parameter int unsigned MANTIS_SIZE = 23,
    parameter int unsigned EXP_SIZE    = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          sign_in;
    logic [EXP_SIZE-1:0]           exp_in;
    logic [MANTIS_SIZE+2:0]        mantis_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [EXP_SIZE+MANTIS_SIZE:0] result;
    logic                          inexact;
    logic                          overflow;

    modport master (
        output in_valid, sign_in, exp_in, mantis_in, out_ready,
        input  in_ready, out_valid, result, inexact, overflow
    );

    modport slave (
        input  in_valid, sign_in, exp_in, mantis_in, out_ready,
        output in_ready, out_valid, result, inexact, overflow
    );
endinterface

// File: rtl/fp_round.sv
// Round-to-nearest-even and pack stage: s1 holds the rounded mantissa, the output register
// holds the packed word; both stages stall independently under backpressure.
module fp_round #(
    parameter int unsigned MANTIS_SIZE = 23,
    parameter int unsigned EXP_SIZE    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_round_if.slave     bus
);
    localparam int unsigned SW = MANTIS_SIZE + 2;
    localparam int unsigned EW = EXP_SIZE + 1;
    localparam int unsigned RW = 1 + EXP_SIZE + MANTIS_SIZE;

    logic                   w_special;
    logic                   w_g;
    logic                   w_s;
    logic                   w_lsb;
    logic                   w_inc;
    logic [SW-1:0]          w_sum;
    logic                   w_adv1;
    logic                   w_adv2;

    logic                   r_s1_valid;
    logic [SW-1:0]          r_sum;
    logic [EXP_SIZE-1:0]    r_exp_s1;
    logic                   r_sign_s1;
    logic                   r_special_s1;
    logic                   r_inexact_s1;

    logic [EW-1:0]          w_exp_ext;
    logic [EXP_SIZE-1:0]    w_exp;
    logic [MANTIS_SIZE-1:0] w_frac;
    logic                   w_ovf;

    logic                   r_out_valid;
    logic [RW-1:0]          r_result;
    logic                   r_inexact;
    logic                   r_overflow;

    // Stage 1: round decision; all-ones exponent (inf/NaN) passes through unrounded
    assign w_special = &bus.exp_in;
    assign w_lsb     = bus.mantis_in[2];
    assign w_g       = bus.mantis_in[1];
    assign w_s       = bus.mantis_in[0];
    assign w_inc     = ~w_special & w_g & (w_s | w_lsb);
    assign w_sum     = {1'b0, bus.mantis_in[MANTIS_SIZE+2:2]} + SW'(w_inc);

    assign w_adv2       = ~r_out_valid | bus.out_ready;
    assign w_adv1       = ~r_s1_valid | w_adv2;
    assign bus.in_ready = w_adv1 & rst_n;

    // Stage 2: mantissa carry, denormal promotion and saturation to infinity
    always_comb begin
        w_exp_ext = {1'b0, r_exp_s1};
        w_frac    = r_sum[MANTIS_SIZE-1:0];
        if (r_sum[SW-1]) begin
            w_exp_ext = {1'b0, r_exp_s1} + EW'(1);
            w_frac    = '0;
        end else if ((r_exp_s1 == '0) && r_sum[MANTIS_SIZE]) begin
            w_exp_ext = EW'(1);
        end
        w_ovf = ~r_special_s1 & (w_exp_ext[EXP_SIZE] | (&w_exp_ext[EXP_SIZE-1:0]));
        w_exp = w_exp_ext[EXP_SIZE-1:0];
        if (w_ovf) begin
            w_exp  = '1;
            w_frac = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_sum        <= '0;
            r_exp_s1     <= '0;
            r_sign_s1    <= 1'b0;
            r_special_s1 <= 1'b0;
            r_inexact_s1 <= 1'b0;
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_inexact    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_sum        <= w_sum;
                    r_exp_s1     <= bus.exp_in;
                    r_sign_s1    <= bus.sign_in;
                    r_special_s1 <= w_special;
                    r_inexact_s1 <= (w_g | w_s) & ~w_special;
                end
            end
            if (w_adv2) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result   <= {r_sign_s1, w_exp, w_frac};
                    r_inexact  <= r_inexact_s1;
                    r_overflow <= w_ovf;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.inexact   = r_inexact;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_fp_round.sv
// Self-checking bench for fp_round: directed IEEE single-precision cases, a randomized
// stream under random backpressure, stall behaviour and mid-flight reset.
module tb_fp_round;
    localparam int unsigned MS   = 23;
    localparam int unsigned ES   = 8;
    localparam int unsigned RW   = 1 + ES + MS;
    localparam int unsigned EMAX = (1 << ES) - 1;

    typedef struct {
        logic          s;
        logic [ES-1:0] e;
        logic [MS+2:0] m;
        logic [RW-1:0] res;
        logic          inx;
        logic          ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_round_if #(.MANTIS_SIZE(MS), .EXP_SIZE(ES)) bus ();
    fp_round #(.MANTIS_SIZE(MS), .EXP_SIZE(ES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t stim[$];

    // Reference: integer rounding of the 24-bit significand, then exponent fix-up
    function automatic vec_t mk(input logic s, input logic [ES-1:0] e, input logic [MS+2:0] m);
        vec_t v;
        int unsigned r;
        int unsigned ex;
        v.s = s; v.e = e; v.m = m;
        if (32'(e) == EMAX) begin
            v.res = {s, e, m[MS+1:2]};
            v.inx = 1'b0;
            v.ovf = 1'b0;
            return v;
        end
        r  = 32'(m[MS+2:2]);
        if (m[1] && (m[0] || m[2])) r = r + 1;
        ex = 32'(e);
        v.inx = m[1] | m[0];
        v.ovf = 1'b0;
        if (r >= (32'd1 << (MS + 1))) begin
            ex = ex + 1;
            r  = 0;
        end else if (ex == 0 && r >= (32'd1 << MS)) begin
            ex = 1;
        end
        if (ex >= EMAX) begin
            ex = EMAX; r = 0; v.ovf = 1'b1;
        end
        v.res = {s, ES'(ex), MS'(r)};
        return v;
    endfunction

    function automatic vec_t mkd(input logic s, input logic [ES-1:0] e, input logic [MS+2:0] m,
                                 input logic [RW-1:0] res, input logic inx, input logic ovf);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.res = res; v.inx = inx; v.ovf = ovf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.sign_in   = v.s;
        bus.exp_in    = v.e;
        bus.mantis_in = v.m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.sign_in = 1'b0; bus.exp_in = '0; bus.mantis_in = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if ({bus.result, bus.inexact, bus.overflow} !== '0) begin bad++; $display("FAIL reset_data: got %h/%b/%b want 0", bus.result, bus.inexact, bus.overflow); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_latency();
        vec_t v = mkd(1'b0, 8'h7F, 26'h2000000, 32'h3F800000, 1'b0, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(v);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got out_valid %b want 0", bus.out_valid); end
        @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1 || {bus.result, bus.inexact, bus.overflow} !== {v.res, v.inx, v.ovf})
            begin bad++; $display("FAIL lat_result: got v=%b %h/%b/%b want v=1 %h/%b/%b", bus.out_valid, bus.result, bus.inexact, bus.overflow, v.res, v.inx, v.ovf); end
        @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain: got out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_round_stream(input int n_random);
        vec_t cur;
        vec_t ev;
        bit   have = 1'b0;
        bit   held = 1'b0;
        logic [RW-1:0] held_res = '0;
        int   cyc = 0;
        logic [MS+2:0] m;
        stim.push_back(mkd(1'b0, 8'h7F, 26'h2000002, 32'h3F800000, 1'b1, 1'b0));
        stim.push_back(mkd(1'b0, 8'h7F, 26'h2000006, 32'h3F800002, 1'b1, 1'b0));
        stim.push_back(mkd(1'b0, 8'h7F, 26'h3FFFFFF, 32'h40000000, 1'b1, 1'b0));
        stim.push_back(mkd(1'b0, 8'hFE, 26'h3FFFFFF, 32'h7F800000, 1'b1, 1'b1));
        stim.push_back(mkd(1'b0, 8'hFF, 26'h3000000, 32'h7FC00000, 1'b0, 1'b0));
        stim.push_back(mkd(1'b0, 8'h00, 26'h1FFFFFE, 32'h00800000, 1'b1, 1'b0));
        stim.push_back(mkd(1'b0, 8'h00, 26'h0000005, 32'h00000001, 1'b1, 1'b0));
        stim.push_back(mkd(1'b1, 8'h00, 26'h0000000, 32'h80000000, 1'b0, 1'b0));
        stim.push_back(mkd(1'b1, 8'h80, 26'h248D15B, 32'hC0123457, 1'b1, 1'b0));
        for (int i = 0; i < n_random; i++) begin
            m = 26'($urandom);
            if ($urandom_range(3) == 0) m[MS+1:2] = '1;
            stim.push_back(mk(1'($urandom), ES'($urandom_range(EMAX)), m));
        end
        while ((stim.size() > 0 || have || sb.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!have && stim.size() > 0 && $urandom_range(3) != 0) begin
                cur  = stim.pop_front();
                have = 1'b1;
            end
            if (have) drive(cur);
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(3) != 0);
            #1;
            if (held) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.result !== held_res) begin
                    bad++; $display("FAIL stall_stable: got v=%b %h want v=1 %h", bus.out_valid, bus.result, held_res);
                end
            end
            held     = bus.out_valid && !bus.out_ready;
            held_res = bus.result;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL stream_extra: got %h want no output", bus.result);
                end else begin
                    ev = sb.pop_front();
                    if ({bus.result, bus.inexact, bus.overflow} !== {ev.res, ev.inx, ev.ovf}) begin
                        bad++; $display("FAIL stream_result: in %b/%h/%h got %h/%b/%b want %h/%b/%b",
                                        ev.s, ev.e, ev.m, bus.result, bus.inexact, bus.overflow, ev.res, ev.inx, ev.ovf);
                    end
                end
            end
            if (have && bus.in_ready) begin
                sb.push_back(cur);
                have = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        total++; if (cyc >= 4000) begin bad++; $display("FAIL stream_timeout: got %0d pending want 0", sb.size()); end
        stim.delete();
        sb.delete();
    endtask

    task automatic test_back_to_back();
        vec_t a = mk(1'b0, 8'h7F, 26'h2000006);
        vec_t b = mk(1'b1, 8'h10, 26'h3FFFFFF);
        vec_t c = mk(1'b0, 8'h00, 26'h0000007);
        vec_t ev;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(a);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a: got %b want 1", bus.in_ready); end
        sb.push_back(a);
        @(negedge clk);
        drive(b);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_b: got %b want 1", bus.in_ready); end
        sb.push_back(b);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(c);
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_%0d: got in_ready %b want 0", i, bus.in_ready); end
            total++; if (bus.out_valid !== 1'b1 || bus.result !== a.res)
                begin bad++; $display("FAIL bp_hold_%0d: got v=%b %h want v=1 %h", i, bus.out_valid, bus.result, a.res); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        sb.push_back(c);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                #1;
            end
            ev = sb.pop_front();
            total++; if (bus.out_valid !== 1'b1 || {bus.result, bus.inexact, bus.overflow} !== {ev.res, ev.inx, ev.ovf})
                begin bad++; $display("FAIL bp_drain_%0d: got v=%b %h/%b/%b want v=1 %h/%b/%b", i, bus.out_valid, bus.result, bus.inexact, bus.overflow, ev.res, ev.inx, ev.ovf); end
        end
        @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got out_valid %b result %h want 0", bus.out_valid, bus.result); end
    endtask

    task automatic test_reset_midflight();
        vec_t a = mk(1'b0, 8'h81, 26'h2ABCDEF);
        vec_t d = mk(1'b1, 8'h7E, 26'h2000003);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(a);
        @(negedge clk);
        drive(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0 || {bus.result, bus.inexact, bus.overflow} !== '0)
            begin bad++; $display("FAIL rst_flush: got v=%b %h/%b/%b want all 0", bus.out_valid, bus.result, bus.inexact, bus.overflow); end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_%0d: got out_valid %b result %h want 0", i, bus.out_valid, bus.result); end
        end
        @(negedge clk);
        drive(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1 || {bus.result, bus.inexact, bus.overflow} !== {d.res, d.inx, d.ovf})
            begin bad++; $display("FAIL rst_after: got v=%b %h/%b/%b want v=1 %h/%b/%b", bus.out_valid, bus.result, bus.inexact, bus.overflow, d.res, d.inx, d.ovf); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_stream(300);
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end
endmodule
